// File: rtl/gemmini_pkg.sv
// Shared gemmini definitions: default mesh geometry plus the response-tag
// and write-entry layouts used by the mesh response writer.
package gemmini_pkg;

  localparam int DIM    = 16;  // mesh columns per row
  localparam int IN_W   = 20;  // mesh output element width
  localparam int OUT_W  = 32;  // write-lane width
  localparam int ADDR_W = 14;
  localparam int ROB_W  = 6;
  localparam int ROW_W  = 5;

  // Tag travelling alongside every mesh response beat.
  typedef struct packed {
    logic             rob_id_valid;
    logic [ROB_W-1:0] rob_id;
    logic             is_acc_addr;
    logic             accumulate;
    logic             is_garbage;
    logic [ADDR_W-1:0] addr;
    logic [ROW_W-1:0] rows;
    logic [ROW_W-1:0] cols;
  } resp_tag_t;

  // One buffered write beat at the default geometry. The writer packs its
  // FIFO entries in this same field order.
  typedef struct packed {
    logic              acc;
    logic              accumulate;
    logic [ADDR_W-1:0] addr;
    logic [DIM-1:0]    mask;
    logic [DIM*OUT_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/mesh_resp_fifo.sv
// Small write buffer between the mesh response stream and the write port.
// Entries become visible one cycle after they are pushed; a push while full
// is accepted only when a pop frees a slot in the same cycle.
module mesh_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  // Empty FIFO presents zeros so the write outputs read 0 out of reset.
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/mesh_resp_writer.sv
// Turns mesh response rows into masked, formatted scratchpad/accumulator
// write beats, buffered through a small FIFO, and reports tile completion.
module mesh_resp_writer #(
  parameter int DIM   = gemmini_pkg::DIM,
  parameter int IN_W  = gemmini_pkg::IN_W,
  parameter int OUT_W = gemmini_pkg::OUT_W,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_resp_valid,
  input  logic                  in_resp_tag_rob_id_valid,
  input  logic [5:0]            in_resp_tag_rob_id,
  input  logic                  in_resp_tag_is_acc_addr,
  input  logic                  in_resp_tag_accumulate,
  input  logic                  in_resp_tag_is_garbage,
  input  logic [13:0]           in_resp_tag_addr,
  input  logic [4:0]            in_resp_tag_rows,
  input  logic [4:0]            in_resp_tag_cols,
  input  logic [4:0]            in_resp_total_rows,
  input  logic                  in_resp_last,
  input  logic [DIM*IN_W-1:0]   in_resp_data,
  output logic                  out_wr_valid,
  input  logic                  out_wr_ready,
  output logic                  out_wr_acc,
  output logic                  out_wr_accumulate,
  output logic [13:0]           out_wr_addr,
  output logic [DIM-1:0]        out_wr_mask,
  output logic [DIM*OUT_W-1:0]  out_wr_data,
  output logic                  out_done_valid,
  output logic [5:0]            out_done_rob_id,
  output logic                  err_overflow,
  output logic                  err_row_mismatch
);

  localparam int ENT_W = 2 + 14 + DIM + DIM*OUT_W;
  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(127);
  localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-128);

  gemmini_pkg::resp_tag_t tag;
  logic                 push_req, pop, fifo_full;
  logic [13:0]          row_addr;
  logic [DIM-1:0]       lane_mask;
  logic [DIM*OUT_W-1:0] lane_data;
  logic [ENT_W-1:0]     push_ent, pop_ent;

  logic [4:0] row_idx_q, row_idx_d;
  logic       done_valid_q, done_valid_d;
  logic [5:0] done_rob_q, done_rob_d;
  logic       err_ovf_q, err_ovf_d;
  logic       err_mis_q, err_mis_d;

  assign tag = {in_resp_tag_rob_id_valid, in_resp_tag_rob_id, in_resp_tag_is_acc_addr,
                in_resp_tag_accumulate, in_resp_tag_is_garbage, in_resp_tag_addr,
                in_resp_tag_rows, in_resp_tag_cols};

  // Rows past tag.rows and garbage tiles still advance the row counter.
  assign push_req = in_resp_valid & ~tag.is_garbage & (row_idx_q < tag.rows);
  assign row_addr = tag.addr + {9'd0, row_idx_q};
  assign pop      = out_wr_valid & out_wr_ready;

  // Per-lane mask and formatting: accumulator lanes keep full precision,
  // scratchpad lanes saturate to int8; both sign-extend to the lane width.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    logic signed [IN_W-1:0] raw, sat;
    assign raw = in_resp_data[gi*IN_W +: IN_W];
    assign sat = (raw > SAT_HI) ? SAT_HI : ((raw < SAT_LO) ? SAT_LO : raw);
    assign lane_data[gi*OUT_W +: OUT_W] = tag.is_acc_addr ? OUT_W'(raw) : OUT_W'(sat);
    assign lane_mask[gi] = (32'(tag.cols) > 32'(gi));
  end

  // Field order matches gemmini_pkg::wr_entry_t.
  assign push_ent = {tag.is_acc_addr, tag.accumulate, row_addr, lane_mask, lane_data};

  mesh_resp_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (push_req),
    .in_data   (push_ent),
    .out_valid (out_wr_valid),
    .out_ready (out_wr_ready),
    .out_data  (pop_ent),
    .full      (fifo_full)
  );

  assign {out_wr_acc, out_wr_accumulate, out_wr_addr, out_wr_mask, out_wr_data} = pop_ent;
  assign out_done_valid   = done_valid_q;
  assign out_done_rob_id  = done_rob_q;
  assign err_overflow     = err_ovf_q;
  assign err_row_mismatch = err_mis_q;

  // Row tracking, completion pulse and sticky error detection.
  always_comb begin
    row_idx_d    = row_idx_q;
    done_valid_d = 1'b0;
    done_rob_d   = '0;
    err_ovf_d    = err_ovf_q;
    err_mis_d    = err_mis_q;
    if (in_resp_valid) begin
      row_idx_d = in_resp_last ? 5'd0 : row_idx_q + 5'd1;
      if (in_resp_last) begin
        if (row_idx_q != in_resp_total_rows - 5'd1) err_mis_d = 1'b1;
        if (tag.rob_id_valid) begin
          done_valid_d = 1'b1;
          done_rob_d   = tag.rob_id;
        end
      end
    end
    if (push_req & fifo_full & ~pop) err_ovf_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_idx_q    <= '0;
      done_valid_q <= 1'b0;
      done_rob_q   <= '0;
      err_ovf_q    <= 1'b0;
      err_mis_q    <= 1'b0;
    end else begin
      row_idx_q    <= row_idx_d;
      done_valid_q <= done_valid_d;
      done_rob_q   <= done_rob_d;
      err_ovf_q    <= err_ovf_d;
      err_mis_q    <= err_mis_d;
    end
  end

endmodule

// File: doc/mesh_resp_writer.md
MESH_RESP_WRITER -- requirements
Module: mesh_resp_writer

Interface
REQ-001 SHALL have parameters: DIM, default 16, mesh columns per row; IN_W, default 20, mesh output element width; OUT_W, default 32, write-lane width; DEPTH, default 4, write-FIFO entries (power of two).
REQ-002 SHALL have these ports, in this order (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_resp_valid  in  1  mesh response beat valid; no backpressure.
- in_resp_tag_rob_id_valid  in  1  ROB id present.
- in_resp_tag_rob_id  in  6  ROB id.
- in_resp_tag_is_acc_addr  in  1  target is accumulator.
- in_resp_tag_accumulate  in  1  accumulate-vs-overwrite.
- in_resp_tag_is_garbage  in  1  discard tile.
- in_resp_tag_addr  in  14  base row address.
- in_resp_tag_rows  in  5  valid rows.
- in_resp_tag_cols  in  5  valid columns.
- in_resp_total_rows  in  5  rows the mesh emits for this tile.
- in_resp_last  in  1  final beat of tile.
- in_resp_data  in  DIM*IN_W  row, lane i at [i*IN_W +: IN_W], signed.
- out_wr_valid  out  1  write beat valid.
- out_wr_ready  in  1  sink accepts.
- out_wr_acc  out  1  copy of is_acc_addr.
- out_wr_accumulate  out  1  copy of accumulate.
- out_wr_addr  out  14  row address.
- out_wr_mask  out  DIM  per-lane write enable.
- out_wr_data  out  DIM*OUT_W  formatted row.
- out_done_valid  out  1  one-cycle tile-complete pulse.
- out_done_rob_id  out  6  ROB id of completed tile.
- err_overflow  out  1  sticky: beat lost to full FIFO.
- err_row_mismatch  out  1  sticky: last arrived at wrong row index.

Function
REQ-003 SHALL keep 5-bit row counter row_idx; increment on each in_resp_valid beat; clear to 0 on a beat with in_resp_last=1.
REQ-004 SHALL push a FIFO entry only when in_resp_valid=1, in_resp_tag_is_garbage=0 and row_idx < in_resp_tag_rows; all other beats still advance row_idx.
REQ-005 SHALL compute out_wr_addr = in_resp_tag_addr + row_idx, modulo 2^14 (wrap-around).
REQ-006 SHALL set out_wr_mask[i]=1 iff i < in_resp_tag_cols; tag_cols=0 gives all-zero mask; tag_cols >= DIM gives all-one mask.
REQ-007 SHALL format each acc-bound lane (is_acc_addr=1) as the IN_W-bit value sign-extended to OUT_W.
REQ-008 SHALL format each spad-bound lane (is_acc_addr=0) by saturating to signed 8 bits ([-128, 127]), sign-extended to OUT_W.
REQ-009 SHALL register the formatted entry, giving push-to-out_wr_valid latency of 1 cycle when the FIFO is empty.
REQ-010 SHALL pop on out_wr_valid & out_wr_ready; out_wr_valid=0 when empty; outputs stable while valid & !ready.
REQ-011 SHALL accept a push when full only if a pop occurs in the same cycle; otherwise drop the beat and set err_overflow.
REQ-012 SHALL pulse out_done_valid for exactly 1 cycle, the cycle after a last beat with rob_id_valid=1, carrying that rob_id; garbage tiles also pulse.
REQ-013 SHALL set err_row_mismatch when in_resp_last=1 and row_idx != in_resp_total_rows-1; the counter still clears.
REQ-014 SHALL treat a last beat with total_rows=1 and row_idx=0 as a complete one-beat tile.

Reset
REQ-015 SHALL, while rst=0 (including mid-tile or mid-stall), asynchronously clear the FIFO pointers, row_idx, out_wr_valid, out_done_valid, err_overflow and err_row_mismatch to 0; data outputs read 0.
REQ-016 SHALL clear sticky errors only by reset.

Structure
REQ-017 SHALL place DIM, IN_W, OUT_W, the response-tag typedef and the write-entry typedef in the shared gemmini package.
REQ-018 SHALL implement buffering as one sub-module, mesh_resp_fifo (DEPTH entries, valid/ready out, full flag).

Verification
REQ-019 SHALL cover: tile addr=0x100, rows=16, cols=16, total_rows=16, spad -> 16 writes at 0x100..0x10F, mask 0xFFFF, one done pulse.
REQ-020 SHALL cover: lane values 300 and -300 to spad -> 127 and -128; the same values to acc -> 300 and -300.
REQ-021 SHALL cover: rows=3, cols=5, total_rows=16 -> 3 writes, mask 0x001F, 13 beats dropped, no error.
REQ-022 SHALL cover: out_wr_ready=0, 6 valid beats, DEPTH=4 -> 4 retained, err_overflow=1; simultaneous push+pop when full -> no loss.
REQ-023 SHALL cover: addr=0x3FFE, rows=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; garbage tile -> 0 writes but one done pulse.
REQ-024 SHALL cover: rst asserted after 5 beats of a 16-row tile -> all outputs 0 immediately; the next tile restarts at row 0.
